// File: rtl/data_mem_lsu.sv
// data_mem_lsu: data memory behind the MEM stage of the RISC-V datapath.
//   Byte/halfword/word loads and stores, with sign or zero extension on loads.
//   Reads are registered, so the response arrives one cycle after acceptance.
//   Misaligned, illegal-funct3 and out-of-range requests report a fault.
//   After every reset the memory is cleared, one word per cycle.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only once clear is done
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V funct3 selecting size and sign
//   req_addr          byte address (ADDR_W bits)
//   req_wdata         store data, low lanes used for SB/SH
//   rsp_valid         one-cycle pulse per accepted request
//   rsp_rdata         extended load data; zero for stores and faults
//   rsp_fault         accepted request was misaligned, illegal or out of range
//   init_done         post-reset memory clear has completed
module data_mem_lsu #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_fault_q, rsp_fault_d;
  logic [31:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]   idx_s;
  logic [1:0]         lane_s;
  logic [1:0]         size_s;     // 0 byte, 1 half, 2 word
  logic               signed_s;
  logic               legal_s;
  logic               aligned_s;
  logic               in_range_s;
  logic               fault_s;
  logic               accept_s;
  logic [31:0]        rd_word_s;
  logic [31:0]        shifted_s;
  logic [31:0]        load_data_s;
  logic               mem_we_s;
  logic [IDX_W-1:0]   mem_widx_s;
  logic [3:0]         mem_wbe_s;
  logic [31:0]        mem_wdata_s;

  assign idx_s      = req_addr[ADDR_W-1:2];
  assign lane_s     = req_addr[1:0];
  assign in_range_s = (int'(idx_s) < DEPTH);
  assign req_ready  = (state_q == ST_READY);
  assign init_done  = (state_q == ST_READY);
  assign accept_s   = req_valid & (state_q == ST_READY);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_fault  = rsp_fault_q;

  // Decode funct3 into access size, signedness and legality for the direction.
  always_comb begin
    size_s   = 2'd0;
    signed_s = 1'b0;
    legal_s  = 1'b0;
    case (req_funct3)
      3'b000: begin size_s = 2'd0; signed_s = 1'b1; legal_s = 1'b1;     end
      3'b001: begin size_s = 2'd1; signed_s = 1'b1; legal_s = 1'b1;     end
      3'b010: begin size_s = 2'd2; signed_s = 1'b0; legal_s = 1'b1;     end
      3'b100: begin size_s = 2'd0; signed_s = 1'b0; legal_s = ~req_we; end
      3'b101: begin size_s = 2'd1; signed_s = 1'b0; legal_s = ~req_we; end
      default: begin size_s = 2'd0; signed_s = 1'b0; legal_s = 1'b0;    end
    endcase
  end

  // Alignment check and overall fault flag.
  always_comb begin
    aligned_s = 1'b1;
    case (size_s)
      2'd1:    aligned_s = ~lane_s[0];
      2'd2:    aligned_s = (lane_s == 2'b00);
      default: aligned_s = 1'b1;
    endcase
    fault_s = ~(legal_s & aligned_s & in_range_s);
  end

  // Read the addressed word and extract/extend the requested lane.
  always_comb begin
    rd_word_s   = 32'h0000_0000;
    load_data_s = 32'h0000_0000;
    if (in_range_s) begin
      rd_word_s = mem_q[idx_s];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
    shifted_s = rd_word_s >> {lane_s, 3'b000};
    case (size_s)
      2'd0:    load_data_s = {{24{shifted_s[7] & signed_s}}, shifted_s[7:0]};
      2'd1:    load_data_s = {{16{shifted_s[15] & signed_s}}, shifted_s[15:0]};
      default: load_data_s = rd_word_s;
    endcase
  end

  // Clear sequencing and the accept-path response values.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rsp_valid_d = accept_s;
    rsp_fault_d = accept_s & fault_s;
    rsp_rdata_d = 32'h0000_0000;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        if (accept_s & ~req_we & ~fault_s) begin
          rsp_rdata_d = load_data_s;
        end else begin
          rsp_rdata_d = 32'h0000_0000;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Memory write port: clear writes in CLEAR, byte-enabled stores in READY.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = '0;
    mem_wbe_s   = 4'b0000;
    mem_wdata_s = 32'h0000_0000;
    if (state_q == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_ptr_q;
      mem_wbe_s   = 4'b1111;
      mem_wdata_s = 32'h0000_0000;
    end else if (accept_s & req_we & ~fault_s) begin
      mem_we_s   = 1'b1;
      mem_widx_s = idx_s;
      case (size_s)
        2'd0: begin
          mem_wbe_s   = 4'b0001 << lane_s;
          mem_wdata_s = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          mem_wbe_s   = lane_s[1] ? 4'b1100 : 4'b0011;
          mem_wdata_s = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_wbe_s   = 4'b1111;
          mem_wdata_s = req_wdata;
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Memory array; contents only change through the write port, not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe_s[b]) begin
          mem_q[mem_widx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Testbench for data_mem_lsu. Two instances share all inputs: the default
// DEPTH=128 and a DEPTH=100 one so that the range fault is reachable.
// Expected responses are computed by a byte-level reference model and queued
// at acceptance; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready_v;
  logic [1:0]  rsp_valid_v;
  logic [1:0]  rsp_fault_v;
  logic [1:0]  init_done_v;
  logic [31:0] rsp_rdata_v [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [31:0] mm [2][128];
  int          dep [2] = '{128, 100};

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH(128), .ADDR_W(9)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_v[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_v[0]),
    .rsp_fault(rsp_fault_v[0]), .init_done(init_done_v[0])
  );

  data_mem_lsu #(.DEPTH(100), .ADDR_W(9)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_v[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_v[1]),
    .rsp_fault(rsp_fault_v[1]), .init_done(init_done_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: {fault, rdata}; stores update the model memory.
  function automatic logic [32:0] model(input int d, input bit we, input logic [2:0] f3,
                                        input logic [8:0] a, input logic [31:0] wd);
    int size, off, widx;
    bit ok;
    logic [31:0] w, v, mask;
    if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    widx = int'(a) / 4;
    off  = int'(a) % 4;
    if (ok && (int'(a) % size != 0)) ok = 1'b0;
    if (ok && (widx >= dep[d])) ok = 1'b0;
    if (!ok) return {1'b1, 32'h0000_0000};
    if (we) begin
      for (int b = 0; b < size; b++) mm[d][widx][8*(off+b) +: 8] = wd[8*b +: 8];
      return {1'b0, 32'h0000_0000};
    end
    w = mm[d][widx];
    v = w >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    v = v & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*size-1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  function automatic logic [32:0] pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    else        return exp_q1.pop_front();
  endfunction

  task automatic monitor_one(input int d);
    logic [32:0] e;
    bit have;
    have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (rsp_valid_v[d]) begin
      if (!have) begin
        total_cnt++;
        $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected 0 (t=%0t)", d, $time);
      end else begin
        e = pop_exp(d);
        chk($sformatf("rsp_fault dut%0d", d), 32'(rsp_fault_v[d]), 32'(e[32]));
        chk($sformatf("rsp_rdata dut%0d", d), rsp_rdata_v[d], e[31:0]);
      end
    end else if (have) begin
      e = pop_exp(d);
      total_cnt++;
      $display("FAIL missing_rsp dut%0d: got rsp_valid=0 expected 1 (t=%0t)", d, $time);
    end else begin
      chk($sformatf("idle_outputs dut%0d", d), rsp_rdata_v[d] | 32'(rsp_fault_v[d]), 32'h0);
    end
  endtask

  // Monitor: decoupled from stimulus, compares whatever the DUTs present.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) monitor_one(d);
    end
  end

  task automatic issue(input bit we, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    exp_q0.push_back(model(0, we, f3, a, wd));
    exp_q1.push_back(model(1, we, f3, a, wd));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Reset, check outputs drop at once, then check clear timing of both DUTs.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 128; i++) mm[d][i] = 32'h0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst rsp_valid dut%0d", d), 32'(rsp_valid_v[d]), 32'h0);
      chk($sformatf("rst init_done dut%0d", d), 32'(init_done_v[d]), 32'h0);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    // Requests during clear must be ignored.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 9'h010;
    req_wdata  = 32'hFFFF_FFFF;
    for (int k = 1; k <= 128; k++) begin
      @(posedge clk);
      #1;
      if (k == 90) req_valid = 1'b0;
      if (k == 99)  chk("init_done dut1 @99", 32'(init_done_v[1]), 32'h0);
      if (k == 100) chk("init_done dut1 @100", 32'(init_done_v[1]), 32'h1);
      if (k == 127) begin
        chk("init_done dut0 @127", 32'(init_done_v[0]), 32'h0);
        chk("req_ready dut0 @127", 32'(req_ready_v[0]), 32'h0);
      end
      if (k == 128) begin
        chk("init_done dut0 @128", 32'(init_done_v[0]), 32'h1);
        chk("req_ready dut0 @128", 32'(req_ready_v[0]), 32'h1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] a;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 9'h000;
    req_wdata  = 32'h0;
    #23;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("por rsp_valid dut%0d", d), 32'(rsp_valid_v[d]), 32'h0);
      chk($sformatf("por rsp_rdata dut%0d", d), rsp_rdata_v[d], 32'h0);
      chk($sformatf("por req_ready dut%0d", d), 32'(req_ready_v[d]), 32'h0);
    end
    do_reset();

    // Cleared memory at the top word (out of range for the 100-word DUT).
    issue(1'b0, 3'b010, 9'h1FC, 32'h0);
    idle(2);
    // Word store then all load flavours, back-to-back.
    issue(1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF);
    issue(1'b0, 3'b000, 9'h013, 32'h0);
    issue(1'b0, 3'b100, 9'h013, 32'h0);
    issue(1'b0, 3'b001, 9'h012, 32'h0);
    issue(1'b0, 3'b101, 9'h010, 32'h0);
    idle(1);
    // Partial stores merge into the word.
    issue(1'b1, 3'b000, 9'h011, 32'h1234_565A);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    issue(1'b1, 3'b001, 9'h012, 32'h0000_1234);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    idle(1);
    // Faults: misaligned, illegal funct3, out of range.
    issue(1'b0, 3'b010, 9'h012, 32'h0);
    issue(1'b1, 3'b001, 9'h011, 32'hFFFF_FFFF);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    issue(1'b0, 3'b011, 9'h010, 32'h0);
    issue(1'b0, 3'b010, 9'h190, 32'h0);
    issue(1'b1, 3'b100, 9'h010, 32'hFFFF_FFFF);
    issue(1'b1, 3'b010, 9'h192, 32'hFFFF_FFFF);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    idle(2);

    // Randomized traffic, biased toward a small address window for reuse.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 1) == 0) a = 9'($urandom_range(0, 63));
        else                           a = 9'($urandom_range(0, 511));
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end
    end
    idle(2);

    // Reset mid-stream drops in-flight responses and re-clears memory.
    issue(1'b1, 3'b010, 9'h010, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    issue(1'b0, 3'b010, 9'h014, 32'h0);
    do_reset();
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    issue(1'b0, 3'b101, 9'h016, 32'h0);
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
